// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: FIFO-buffered 8N1 UART transmitter fed by CPU store strobes
//   clk, rst   : clock, synchronous active-high reset
//   uart       : byte to queue, sampled while uart_we is high
//   uart_we    : write strobe, one byte per high cycle
//   uart_tx    : registered serial line, idle high
//   fifo_full  : FIFO holds FIFO_DEPTH bytes
//   fifo_empty : FIFO holds no bytes
//   tx_busy    : a frame is in progress
//   overflow   : sticky, a write was dropped because the FIFO was full
module uart_tx_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart,
  input  logic       uart_we,
  output logic       uart_tx,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       tx_busy,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [7:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] count;
  state_t state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0] bit_idx, bit_d;
  logic [7:0] shift, shift_d;
  logic tx_d, push, pop, tick;
  assign fifo_full = count == (PTR_W+1)'(FIFO_DEPTH);
  assign fifo_empty = count == '0;
  assign tx_busy = state != IDLE;
  assign push = uart_we && !fifo_full;
  assign tick = baud == BW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_d = state;
    baud_d = tick ? '0 : baud + BW'(1);
    bit_d = bit_idx;
    shift_d = shift;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop = 1'b1;
          state_d = START;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        shift_d = shift >> 1;
        bit_d = bit_idx + 3'd1;
        state_d = bit_idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        pop = !fifo_empty;
        state_d = fifo_empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = mem[rd_ptr];
    // line level is derived from the next state so the pin flop moves with the FSM
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart;
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      uart_tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      baud <= baud_d;
      bit_idx <= bit_d;
      shift <= shift_d;
      uart_tx <= tx_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      // full is the pre-edge value, so a same-cycle pop never rescues the write
      if (uart_we && fifo_full) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: randomized and directed checks of uart_tx_buffer against a frame-level model
module tb_uart_tx_buffer;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_we = 1'b0;
  logic [7:0] uart = 8'h00;
  logic uart_tx, fifo_full, fifo_empty, tx_busy, overflow;
  int total = 0;
  int bad = 0;
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  int ft = 0;
  bit active = 1'b0;
  bit ov = 1'b0;
  logic line_s [300];
  logic empty_s [300];
  int n = 0;
  uart_tx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .uart(uart),
    .uart_we(uart_we),
    .uart_tx(uart_tx),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .tx_busy(tx_busy),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic model_edge(input logic r, input logic we, input logic [7:0] d);
    bit full_pre;
    full_pre = q.size() == DEPTH;
    if (r) begin
      q.delete();
      active = 1'b0;
      ft = 0;
      ov = 1'b0;
    end else begin
      if (active) begin
        if (ft == FRAME - 1) begin
          if (q.size() > 0) begin
            cur = q.pop_front();
            ft = 0;
          end else active = 1'b0;
        end else ft++;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
        active = 1'b1;
        ft = 0;
      end
      if (we) begin
        if (!full_pre) q.push_back(d);
        else ov = 1'b1;
      end
    end
  endtask
  function automatic logic model_tx();
    int b;
    b = ft / CPB;
    if (!active) return 1'b1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction
  function automatic logic [7:0] decode(input int s);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = line_s[s + CPB * (k + 1) + CPB / 2];
    return v;
  endfunction
  task automatic step(input logic r, input logic we, input logic [7:0] d);
    rst = r;
    uart_we = we;
    uart = d;
    @(posedge clk);
    model_edge(r, we, d);
    #1;
  endtask
  task automatic sample();
    line_s[n] = uart_tx;
    empty_s[n] = fifo_empty;
    n++;
  endtask
  function automatic int first_low();
    for (int i = 0; i < n; i++) if (line_s[i] === 1'b0) return i;
    return -1;
  endfunction
  task automatic test_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      total++;
      if ({uart_tx, fifo_empty, fifo_full, tx_busy, overflow} !== 5'b11000) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: tx/empty/full/busy/ovf got %b want 11000", i,
                 {uart_tx, fifo_empty, fifo_full, tx_busy, overflow});
      end
    end
  endtask
  task automatic test_single();
    logic [9:0] pat;
    pat = 10'b1101001010;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 8'hA5);
    total++;
    if (uart_tx !== 1'b1) begin
      bad++;
      $display("FAIL single_latency1: tx got %b want 1", uart_tx);
    end
    step(0, 0, 0);
    total++;
    if (uart_tx !== 1'b0) begin
      bad++;
      $display("FAIL single_latency2: tx got %b want 0", uart_tx);
    end
    for (int i = 0; i < FRAME; i++) begin
      total++;
      if ({uart_tx, tx_busy} !== {pat[i/CPB], 1'b1}) begin
        bad++;
        $display("FAIL single_frame cycle %0d: tx/busy got %b want %b", i, {uart_tx, tx_busy}, {pat[i/CPB], 1'b1});
      end
      step(0, 0, 0);
    end
    total++;
    if ({uart_tx, tx_busy, fifo_empty} !== 3'b101) begin
      bad++;
      $display("FAIL single_end: tx/busy/empty got %b want 101", {uart_tx, tx_busy, fifo_empty});
    end
  endtask
  task automatic test_back_to_back();
    int s;
    step(1, 0, 0);
    n = 0;
    for (int i = 1; i <= 3; i++) begin
      step(0, 1, 8'(i));
      sample();
    end
    repeat (130) begin
      step(0, 0, 0);
      sample();
    end
    s = first_low();
    total++;
    if (s != 1) begin
      bad++;
      $display("FAIL b2b_start: first start bit at sample %0d want 1", s);
      s = 1;
    end
    for (int f = 0; f < 3; f++) begin
      total++;
      if ({line_s[s+FRAME*f-1], line_s[s+FRAME*f], line_s[s+FRAME*f+FRAME-2]} !== 3'b101) begin
        bad++;
        $display("FAIL b2b_edges frame %0d: prev/start/stop got %b want 101", f,
                 {line_s[s+FRAME*f-1], line_s[s+FRAME*f], line_s[s+FRAME*f+FRAME-2]});
      end
      total++;
      if (decode(s + FRAME * f) !== 8'(f + 1)) begin
        bad++;
        $display("FAIL b2b_data frame %0d: got %h want %h", f, decode(s + FRAME * f), 8'(f + 1));
      end
    end
    total++;
    if ({empty_s[s+2*FRAME-1], empty_s[s+2*FRAME]} !== 2'b01) begin
      bad++;
      $display("FAIL b2b_empty: empty before/at third pop got %b want 01", {empty_s[s+2*FRAME-1], empty_s[s+2*FRAME]});
    end
    for (int i = s + 3 * FRAME; i < n; i++) begin
      total++;
      if (line_s[i] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_idle sample %0d: tx got %b want 1", i, line_s[i]);
      end
    end
  endtask
  task automatic test_overflow();
    int s;
    step(1, 0, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h10 + 8'(i));
      sample();
      if (i == 4) begin
        total++;
        if ({fifo_full, overflow} !== 2'b10) begin
          bad++;
          $display("FAIL ovf_full: full/ovf got %b want 10", {fifo_full, overflow});
        end
      end
    end
    total++;
    if ({fifo_full, overflow} !== 2'b11) begin
      bad++;
      $display("FAIL ovf_drop: full/ovf got %b want 11", {fifo_full, overflow});
    end
    repeat (210) begin
      step(0, 0, 0);
      sample();
    end
    s = first_low();
    total++;
    if (s != 1) begin
      bad++;
      $display("FAIL ovf_start: first start bit at sample %0d want 1", s);
      s = 1;
    end
    for (int f = 0; f < 5; f++) begin
      total++;
      if (decode(s + FRAME * f) !== 8'h10 + 8'(f)) begin
        bad++;
        $display("FAIL ovf_data frame %0d: got %h want %h", f, decode(s + FRAME * f), 8'h10 + 8'(f));
      end
    end
    for (int i = s + 5 * FRAME; i < n; i++) begin
      total++;
      if (line_s[i] !== 1'b1) begin
        bad++;
        $display("FAIL ovf_no_sixth sample %0d: tx got %b want 1", i, line_s[i]);
      end
    end
    total++;
    if ({overflow, fifo_empty, tx_busy} !== 3'b110) begin
      bad++;
      $display("FAIL ovf_sticky: ovf/empty/busy got %b want 110", {overflow, fifo_empty, tx_busy});
    end
  endtask
  task automatic test_reset_mid();
    int s;
    step(1, 0, 0);
    step(0, 1, 8'h55);
    step(0, 1, 8'hAA);
    step(0, 1, 8'hBB);
    repeat (14) step(0, 0, 0);
    total++;
    if ({tx_busy, fifo_empty} !== 2'b10) begin
      bad++;
      $display("FAIL mid_pre: busy/empty got %b want 10", {tx_busy, fifo_empty});
    end
    step(1, 0, 0);
    total++;
    if ({uart_tx, fifo_empty, tx_busy, fifo_full} !== 4'b1100) begin
      bad++;
      $display("FAIL mid_abort: tx/empty/busy/full got %b want 1100", {uart_tx, fifo_empty, tx_busy, fifo_full});
    end
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0);
      total++;
      if ({uart_tx, tx_busy} !== 2'b10) begin
        bad++;
        $display("FAIL mid_quiet cycle %0d: tx/busy got %b want 10", i, {uart_tx, tx_busy});
      end
    end
    n = 0;
    step(0, 1, 8'h3C);
    sample();
    for (int i = 0; i < 45; i++) begin
      step(0, 0, 0);
      sample();
      total++;
      if (uart_tx !== model_tx()) begin
        bad++;
        $display("FAIL mid_rewrite cycle %0d: tx got %b want %b", i, uart_tx, model_tx());
      end
    end
    s = first_low();
    total++;
    if (s != 1 || decode(1) !== 8'h3C) begin
      bad++;
      $display("FAIL mid_decode: start %0d byte %h want start 1 byte 3c", s, decode(1));
    end
  endtask
  task automatic test_full_pop();
    bit found;
    found = 1'b0;
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h20 + 8'(i));
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (active && ft == FRAME - 1) found = 1'b1;
      else step(0, 0, 0);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL fullpop_wait: frame end not reached, got 0 want 1");
    end
    total++;
    if ({fifo_full, overflow} !== 2'b10) begin
      bad++;
      $display("FAIL fullpop_pre: full/ovf got %b want 10", {fifo_full, overflow});
    end
    step(0, 1, 8'hEE);
    total++;
    if ({overflow, fifo_full, tx_busy, uart_tx} !== 4'b1010) begin
      bad++;
      $display("FAIL fullpop_post: ovf/full/busy/tx got %b want 1010", {overflow, fifo_full, tx_busy, uart_tx});
    end
    for (int i = 0; i < 4 * FRAME; i++) begin
      step(0, 0, 0);
      total++;
      if ({uart_tx, fifo_empty, fifo_full} !== {model_tx(), q.size() == 0, q.size() == DEPTH}) begin
        bad++;
        $display("FAIL fullpop_drain cycle %0d: tx/empty/full got %b want %b", i, {uart_tx, fifo_empty, fifo_full},
                 {model_tx(), q.size() == 0, q.size() == DEPTH});
      end
    end
  endtask
  task automatic test_random();
    int dens;
    logic r, we;
    dens = 5;
    step(1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) dens = $urandom_range(0, 30);
      r = $urandom_range(0, 599) == 0;
      we = $urandom_range(0, 99) < dens;
      step(r, we, 8'($urandom));
      total++;
      if ({uart_tx, fifo_full, fifo_empty, tx_busy, overflow} !==
          {model_tx(), q.size() == DEPTH, q.size() == 0, active, ov}) begin
        bad++;
        $display("FAIL random cycle %0d: tx/full/empty/busy/ovf got %b want %b", i,
                 {uart_tx, fifo_full, fifo_empty, tx_busy, overflow},
                 {model_tx(), q.size() == DEPTH, q.size() == 0, active, ov});
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
- Downstream consumer of the memory-stage UART outputs: `uart[7:0]` and the `uart_we` strobe.
- Buffers the bytes the CPU stores to the UART address in a small FIFO.
- Serialises them onto a single TX pin as 8N1 frames at a fixed baud divisor.
- The CPU is never stalled. Bytes written while the FIFO is full are dropped, and a sticky overflow flag is set.

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, default 16: number of byte entries. Must be a power of two, ≥ 2.
- `PTR_W`, default $clog2(FIFO_DEPTH): pointer width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `uart`  in  8  byte to transmit, sampled when `uart_we` = 1.
- `uart_we`  in  1  write strobe, one byte per high cycle.
- `uart_tx`  out  1  serial line, idle high. Registered output.
- `fifo_full`  out  1  count == `FIFO_DEPTH`.
- `fifo_empty`  out  1  count == 0.
- `tx_busy`  out  1  high whenever the FSM is not IDLE.
- `overflow`  out  1  sticky: set when a write is dropped; cleared only by `rst`.

Behaviour:
- Reset (synchronous, `rst` = 1 at an edge):
  - FIFO pointers and count go to 0; FSM goes to IDLE; bit and baud counters go to 0.
  - Output values: `uart_tx` = 1, `fifo_full` = 0, `fifo_empty` = 1, `tx_busy` = 0, `overflow` = 0.
  - Reset mid-frame aborts the frame: the line is high from the next cycle and all queued bytes are discarded.
- FIFO:
  - Circular buffer with read and write pointers of `PTR_W` bits (wrap naturally) and a count of `PTR_W`+1 bits.
  - Write accepted iff `uart_we` = 1 and `fifo_full` = 0 in the same cycle. The byte is stored at `wr_ptr` and the pointer increments.
  - `uart_we` = 1 with `fifo_full` = 1: byte dropped, `overflow` ← 1. This holds even if a pop occurs in the same cycle, because full is evaluated on the pre-edge count.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - `fifo_full` and `fifo_empty` are decoded combinationally from the registered count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - If `fifo_empty` = 0: pop the head byte into an 8-bit shift register, clear the baud counter, go to START.
    - Otherwise stay in IDLE with `uart_tx` = 1.
  - START: `uart_tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index = 0.
  - DATA:
    - `uart_tx` = shift[0], LSB first.
    - After each `CLKS_PER_BIT` cycles, shift right and increment the bit index.
    - After bit index 7 completes, go to STOP.
  - STOP:
    - `uart_tx` = 1 for `CLKS_PER_BIT` cycles.
    - At the end: if `fifo_empty` = 0, pop immediately and go to START with no idle gap; else go to IDLE.
  - The baud counter counts 0..`CLKS_PER_BIT`-1 and resets on every bit boundary and on every state entry.
- Timing:
  - Frame length is exactly 10×`CLKS_PER_BIT` cycles; back-to-back frames are contiguous.
  - From empty and IDLE: a write accepted at edge E makes the FIFO non-empty after E. The FSM pops at edge E+1, and `uart_tx` goes low after edge E+1, i.e. 2 cycles of write-to-start-bit latency.
  - The popped slot frees at the pop edge, so the FIFO can hold `FIFO_DEPTH` bytes plus one byte in flight in the shift register.
- `uart_tx` is driven from a flop updated with the FSM, so the pin is glitch-free.

Test Plan (`CLKS_PER_BIT` = 4, `FIFO_DEPTH` = 4):
- Reset then idle 20 cycles → `uart_tx` = 1, `fifo_empty` = 1, `tx_busy` = 0, `overflow` = 0 throughout.
- Single write of 0xA5 → `uart_tx` low 2 cycles after the write edge. Line then carries 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total), then stays high; `tx_busy` falls when IDLE is re-entered.
- Writes of 0x01, 0x02, 0x03 on consecutive cycles → three contiguous 40-cycle frames decoding to 0x01, 0x02, 0x03 with no idle gap; `fifo_empty` returns to 1 at the third pop.
- Six consecutive writes 0x10–0x15 → 0x10 is popped into the shift register, 0x11–0x14 fill the FIFO, and `fifo_full` = 1. 0x15 is dropped and `overflow` = 1, remaining set after the FIFO drains. Serial output is 0x10–0x14 only.
- `rst` asserted at cycle 15 of a 0x55 frame while 2 bytes are queued → `uart_tx` = 1 on the next cycle, `fifo_empty` = 1, no further frames. A subsequent write of 0x3C transmits a correct 0x3C frame.
- Write while full and FSM popping in the same cycle → write still dropped, `overflow` = 1, count = `FIFO_DEPTH`-1 after the edge.
